bit_route_controller: RTL and testbench
=======================================

Name: bit_route_controller

Overview:
- Configures and sequences a per-bit sink-bus router.
- Each sink bit is driven either from the same-index bit of a source bus, or from a shared scalar input.
- Host stages per-bit selections into a shadow mask through a valid/ready port, then commits them.
- The committed mask is applied one bit per cycle, in ascending index order, so downstream sees a deterministic rollout.

Parameters:
- WIDTH, 2, number of sink/source bits (>=1).
- IDX_W, (WIDTH>1 ? $clog2(WIDTH) : 1), width of the bit index.
- RESET_MASK, {WIDTH{1'b0}}, reset value of shadow and active masks (1 = route from scalar_in).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- source_bus  input  WIDTH  per-bit source data.
- scalar_in  input  1  shared scalar source.
- cfg_valid  input  1  config write request.
- cfg_ready  output  1  config write accepted when high with cfg_valid.
- cfg_bit  input  IDX_W  target bit index.
- cfg_sel  input  1  1 = scalar_in, 0 = source_bus[cfg_bit].
- commit  input  1  single-cycle pulse; start applying shadow mask.
- busy  output  1  high while the sweep is in progress.
- sink_bus  output  WIDTH  registered routed output.
- active_mask  output  WIDTH  currently applied selection mask.
- err_idx  output  1  one-cycle pulse: accepted write had cfg_bit >= WIDTH.
- commit_drop  output  1  one-cycle pulse: commit arrived while busy.

Behaviour:
- Reset (async assert, sync deassert use-side):
  - state=IDLE, ptr=0.
  - shadow=active=RESET_MASK.
  - sink_bus=0, busy=0, err_idx=0, commit_drop=0.
  - cfg_ready=1 once state is IDLE.
- FSM states:
  - IDLE: cfg_ready=1, busy=0.
    - Write handshake (cfg_valid&cfg_ready) sets shadow[cfg_bit]<=cfg_sel.
    - commit: ptr<=0, go to SWEEP.
  - SWEEP: cfg_ready=0, busy=1.
    - Each cycle: active[ptr]<=shadow[ptr], ptr<=ptr+1.
    - When ptr==WIDTH-1 the copy happens and the next state is IDLE; ptr wraps to 0.
- Commit latency:
  - commit at cycle N: bit i updates in active_mask at edge N+1+i.
  - busy is high for exactly WIDTH cycles.
- Simultaneous write+commit in IDLE: the write lands in shadow in the same edge and is included in the sweep.
- Boundary conditions:
  - commit while in SWEEP: ignored, commit_drop pulses for 1 cycle, the sweep continues unchanged.
  - cfg_valid while in SWEEP: not accepted (cfg_ready=0); the host must hold cfg_valid.
  - cfg_bit >= WIDTH (non-power-of-2 WIDTH): handshake completes, shadow unchanged, err_idx pulses 1 cycle.
  - WIDTH=1: the sweep lasts 1 cycle.
- Datapath: every edge, sink_bus[i] <= active_mask[i] ? scalar_in : source_bus[i]. Input-to-output latency is 1 cycle.
- Mask-to-output latency: an active_mask change is reflected in sink_bus on the following edge.
- Reset mid-sweep: reverts immediately to reset values; the partially applied mask is discarded.
- No combinational path from any input to any output except cfg_ready (state-only).

Optional Feature:
- Macro: BIT_ROUTE_ATOMIC_COMMIT_EN.
- When defined:
  - SWEEP state is removed; commit in IDLE copies the whole shadow into active in one edge.
  - busy is held at 0; commit_drop is tied to 0.
  - cfg_ready stays 1 permanently.
  - Simultaneous write+commit: the write is included.
- When undefined: the sequential one-bit-per-cycle sweep described above.

Test Plan:
- Reset release, WIDTH=2, source_bus=2'b10, scalar_in=0 -> after 1 edge sink_bus=2'b10, active_mask=2'b00, cfg_ready=1.
- Write bit0 sel=1, then commit, scalar_in=1, source_bus=2'b10 -> mask rollout:
  - active_mask=2'b01 one edge after commit, with busy=1 for 2 cycles and 2'b01 held at the end.
  - sink_bus=2'b11 one edge after the mask change.
- Write bit1=1 and commit in the same cycle, starting from mask 2'b01 -> active_mask goes 2'b01 then 2'b11; commit_drop stays 0.
- commit pulsed again in the 1st SWEEP cycle -> commit_drop=1 for 1 cycle; the sweep still finishes after 2 cycles.
- cfg_valid held during SWEEP -> cfg_ready=0 until IDLE, then accepted exactly once.
- WIDTH=3, cfg_bit=3 -> err_idx=1 for 1 cycle, shadow unchanged.
- rst asserted mid-sweep -> active_mask=RESET_MASK, busy=0, sink_bus=0 immediately.
- Repeat the rollout test with BIT_ROUTE_ATOMIC_COMMIT_EN -> both bits update on the same edge, busy never asserted.

Source files
------------

// File: rtl/bit_route_controller.sv
// bit_route_controller: stages per-bit sink routing selections and rolls them out one bit per cycle.
// Define BIT_ROUTE_ATOMIC_COMMIT_EN to apply the whole shadow mask in a single edge instead.
module bit_route_controller #(
   parameter int               WIDTH      = 2,
   parameter int               IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   parameter logic [WIDTH-1:0] RESET_MASK = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] source_bus,
   input  logic             scalar_in,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [IDX_W-1:0] cfg_bit,
   input  logic             cfg_sel,
   input  logic             commit,
   output logic             busy,
   output logic [WIDTH-1:0] sink_bus,
   output logic [WIDTH-1:0] active_mask,
   output logic             err_idx,
   output logic             commit_drop
);
   logic [WIDTH-1:0] shadow_q, shadow_d, active_q, active_d, sink_q;
   logic             err_q, wr, in_range;

   assign in_range    = {1'b0, cfg_bit} < (IDX_W + 1)'(WIDTH);
   assign wr          = cfg_valid && cfg_ready;
   assign sink_bus    = sink_q;
   assign active_mask = active_q;
   assign err_idx     = err_q;

`ifdef BIT_ROUTE_ATOMIC_COMMIT_EN
   assign cfg_ready   = 1'b1;
   assign busy        = 1'b0;
   assign commit_drop = 1'b0;

   // Merge the host write into the shadow; a commit copies the merged shadow in one edge.
   always_comb begin
      shadow_d = shadow_q;
      if (wr && in_range) shadow_d[cfg_bit] = cfg_sel;
      active_d = commit ? shadow_d : active_q;
   end
`else
   typedef enum logic {IDLE, SWEEP} state_t;
   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             drop_q, drop_d, last;

   assign cfg_ready   = state_q == IDLE;
   assign busy        = state_q == SWEEP;
   assign commit_drop = drop_q;
   assign last        = ptr_q == IDX_W'(WIDTH - 1);

   // Accept writes and commits while idle; while sweeping copy one shadow bit per cycle.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      shadow_d = shadow_q;
      active_d = active_q;
      drop_d   = 1'b0;
      if (state_q == IDLE) begin
         if (wr && in_range) shadow_d[cfg_bit] = cfg_sel;
         if (commit) begin
            state_d = SWEEP;
            ptr_d   = '0;
         end
      end else begin
         active_d[ptr_q] = shadow_q[ptr_q];
         ptr_d           = last ? '0 : ptr_q + 1'b1;
         state_d         = last ? IDLE : SWEEP;
         drop_d          = commit;
      end
   end

   // Sweep state, pointer and dropped-commit pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         drop_q  <= drop_d;
      end
   end
`endif

   // Masks, routed output and out-of-range index pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= RESET_MASK;
         active_q <= RESET_MASK;
         sink_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         sink_q   <= (active_q & {WIDTH{scalar_in}}) | (~active_q & source_bus);
         err_q    <= wr && !in_range;
      end
   end
endmodule

// File: tb/tb_bit_route_controller.sv
// tb_bit_route_controller: randomized check of bit_route_controller against a rollout-schedule model.
module tb_bit_route_controller;
   localparam int             W  = 3;
   localparam int             IW = 2;
   localparam logic [W-1:0]   RM = 3'b101;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  source_bus;
   logic          scalar_in;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [IW-1:0] cfg_bit;
   logic          cfg_sel;
   logic          commit;
   logic          busy;
   logic [W-1:0]  sink_bus;
   logic [W-1:0]  active_mask;
   logic          err_idx;
   logic          commit_drop;

   always #5 clk = ~clk;

   bit_route_controller #(.WIDTH(W), .IDX_W(IW), .RESET_MASK(RM)) dut (
      .clk(clk), .rst(rst), .source_bus(source_bus), .scalar_in(scalar_in),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_bit(cfg_bit), .cfg_sel(cfg_sel),
      .commit(commit), .busy(busy), .sink_bus(sink_bus), .active_mask(active_mask),
      .err_idx(err_idx), .commit_drop(commit_drop)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: a commit at edge s schedules bit i of the committed mask to land at edge s+1+i.
   int           e, s;
   logic [W-1:0] m_sh, m_act, m_tgt, m_sink;
   logic         m_busy, m_err, m_drop;

   task automatic model_reset();
      e = 0; s = -100;
      m_sh = RM; m_act = RM; m_tgt = RM; m_sink = '0;
      m_busy = 1'b0; m_err = 1'b0; m_drop = 1'b0;
   endtask

   task automatic check_all();
`ifdef BIT_ROUTE_ATOMIC_COMMIT_EN
      chk("cfg_ready", 32'(cfg_ready), 32'd1);
`else
      chk("cfg_ready", 32'(cfg_ready), 32'(!m_busy));
`endif
      chk("busy", 32'(busy), 32'(m_busy));
      chk("active_mask", 32'(active_mask), 32'(m_act));
      chk("sink_bus", 32'(sink_bus), 32'(m_sink));
      chk("err_idx", 32'(err_idx), 32'(m_err));
      chk("commit_drop", 32'(commit_drop), 32'(m_drop));
   endtask

   task automatic step();
      logic         pre_busy, acc;
      logic [W-1:0] nsh;
      @(posedge clk);
      e++;
      pre_busy = m_busy;
      for (int i = 0; i < W; i++) m_sink[i] = m_act[i] ? scalar_in : source_bus[i];
`ifdef BIT_ROUTE_ATOMIC_COMMIT_EN
      acc = cfg_valid;
`else
      acc = cfg_valid && !pre_busy;
`endif
      m_err = acc && int'(cfg_bit) >= W;
      nsh = m_sh;
      if (acc && int'(cfg_bit) < W) nsh[cfg_bit] = cfg_sel;
`ifdef BIT_ROUTE_ATOMIC_COMMIT_EN
      m_drop = 1'b0;
      if (commit) m_act = nsh;
      m_busy = 1'b0;
`else
      m_drop = commit && pre_busy;
      for (int i = 0; i < W; i++) if (e == s + 1 + i) m_act[i] = m_tgt[i];
      if (commit && !pre_busy) begin
         s = e;
         m_tgt = nsh;
      end
      m_busy = (e >= s) && (e < s + W);
`endif
      m_sh = nsh;
      #1;
      check_all();
   endtask

   task automatic drive_random();
      source_bus = W'($urandom);
      scalar_in  = 1'($urandom);
      cfg_valid  = 1'($urandom);
      cfg_bit    = IW'($urandom_range(0, 3));
      cfg_sel    = 1'($urandom);
      commit     = $urandom_range(0, 3) == 0;
   endtask

   initial begin
      rst = 1'b1;
      source_bus = 3'b010; scalar_in = 1'b0; cfg_valid = 1'b0;
      cfg_bit = '0; cfg_sel = 1'b0; commit = 1'b0;
      #12;
      chk("reset_active", 32'(active_mask), 32'(RM));
      chk("reset_sink", 32'(sink_bus), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ready", 32'(cfg_ready), 32'd1);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      // directed: write bit1 and commit together
      cfg_valid = 1'b1; cfg_bit = 2'd1; cfg_sel = 1'b1; commit = 1'b1; scalar_in = 1'b1;
      step();
      cfg_valid = 1'b0; commit = 1'b1;
      step();
      commit = 1'b0; cfg_valid = 1'b1; cfg_bit = 2'd3;
      for (int k = 0; k < 4; k++) step();
      cfg_valid = 1'b0;
      for (int k = 0; k < 400; k++) begin
         drive_random();
         step();
      end
      // reset in the middle of a sweep
      cfg_valid = 1'b0; commit = 1'b0;
      for (int k = 0; k < 4; k++) step();
      commit = 1'b1;
      step();
      commit = 1'b0;
      step();
      #2 rst = 1'b1;
      #1;
      chk("midrst_active", 32'(active_mask), 32'(RM));
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_sink", 32'(sink_bus), 32'd0);
      chk("midrst_ready", 32'(cfg_ready), 32'd1);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 200; k++) begin
         drive_random();
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
